pipe_flow_ctrl: RTL and testbench
=================================

PIPE_FLOW_CTRL -- requirements
Module: pipe_flow_ctrl

Interface
REQ-001 SHALL have parameter DELAY, default 3, number of register stages in the controlled delay_unit; legal range 1..64.
REQ-002 SHALL have parameter CNT_W, default $clog2(DELAY+1), width of occupancy count.
REQ-003 SHALL have one clock; reset is asynchronous and active-high, ports named CLK and RST.
REQ-004 SHALL have port CLK  input  1  rising-edge clock.
REQ-005 SHALL have port RST  input  1  async active-high reset.
REQ-006 SHALL have port i_START  input  1  level/pulse; moves IDLE to RUN.
REQ-007 SHALL have port i_FLUSH  input  1  pulse; requests drain of all in-flight data.
REQ-008 SHALL have port i_VALID  input  1  upstream data valid.
REQ-009 SHALL have port o_READY  output  1  upstream may transfer; transfer = i_VALID & o_READY.
REQ-010 SHALL have port o_VALID  output  1  delay_unit output word valid.
REQ-011 SHALL have port i_READY  input  1  downstream accepts; delivery = o_VALID & i_READY.
REQ-012 SHALL have port o_EN  output  1  shift enable to the controlled delay_unit EN.
REQ-013 SHALL have port o_COUNT  output  CNT_W  number of valid words in flight.
REQ-014 SHALL have port o_BUSY  output  1  high in RUN or FLUSH.
REQ-015 SHALL have port o_FLUSH_DONE  output  1  one-cycle pulse, drain complete.

Function
REQ-016 SHALL implement states IDLE, RUN, FLUSH, DONE.
REQ-017 SHALL keep a DELAY-bit valid chain vld[0..DELAY-1] shifting on o_EN; vld[0] loads the transfer bit; o_VALID = vld[DELAY-1].
REQ-018 SHALL drive o_EN = ~vld[DELAY-1] | i_READY in every state (combinational; whole line stalls only when the output word is unconsumed).
REQ-019 SHALL drive o_READY = o_EN & (state==RUN); zero in IDLE, FLUSH, DONE.
REQ-020 SHALL give latency exactly DELAY cycles: a word transferred in cycle t with o_EN high through t+DELAY-1 shows o_VALID in cycle t+DELAY.
REQ-021 SHALL insert bubbles (vld[0]=0) on every o_EN cycle without a transfer.
REQ-022 SHALL update o_COUNT: +1 on transfer, -1 on delivery, unchanged on both or neither; never exceeds DELAY, never underflows.
REQ-023 SHALL transition IDLE->RUN on i_START; IDLE->DONE on i_FLUSH; i_FLUSH wins over simultaneous i_START.
REQ-024 SHALL transition RUN->FLUSH on i_FLUSH; o_READY drops in that same cycle.
REQ-025 SHALL transition FLUSH->DONE in the cycle whose next o_COUNT is 0 (includes last delivery that cycle).
REQ-026 SHALL assert o_FLUSH_DONE only in DONE, for exactly one cycle; DONE->IDLE unconditionally.
REQ-027 SHALL ignore i_START in RUN, FLUSH, DONE and i_FLUSH in FLUSH, DONE.
REQ-028 SHALL drive o_BUSY = (state==RUN)|(state==FLUSH).

Reset
REQ-029 SHALL on RST asynchronously force state IDLE, vld all 0, o_COUNT 0, o_VALID 0, o_READY 0, o_FLUSH_DONE 0, o_BUSY 0; o_EN evaluates to 1.
REQ-030 SHALL treat delay_unit data contents as don't-care after reset; validity is governed solely by vld.
REQ-031 SHALL, on reset mid-RUN/FLUSH, discard in-flight words with no o_FLUSH_DONE pulse.

Structure
REQ-032 SHALL place state encoding constants (IDLE=0, RUN=1, FLUSH=2, DONE=3) in shared package fft_ctrl_pkg.
REQ-033 SHALL implement the valid chain as one delay_unit instance (BITNESS=1, delay=DELAY, ENABLE=1, RESET=1, synch_RESET=0, RESET_LEVEL=1) driven by o_EN.
REQ-034 SHALL keep FSM and counter in the top module; target 120-250 lines RTL.

Verification (DELAY=3)
REQ-035 SHALL test stream: reset, i_START, 5 consecutive transfers from cycle 1, i_READY=1 -> o_VALID high cycles 4..8, o_COUNT max 3, final 0.
REQ-036 SHALL test backpressure: fill 3 words, i_READY=0 -> o_EN=0, o_READY=0, o_COUNT held 3; i_READY=1 -> one delivery/cycle resumes, no word lost or duplicated.
REQ-037 SHALL test flush: 2 words in flight, i_FLUSH -> o_READY=0 same cycle, o_FLUSH_DONE single pulse the cycle after o_COUNT reaches 0, then IDLE.
REQ-038 SHALL test idle flush: i_FLUSH and i_START together in IDLE -> DONE next cycle, o_FLUSH_DONE one cycle, state IDLE, o_BUSY never high.
REQ-039 SHALL test mid-stream reset: RST with o_COUNT=2 -> o_VALID=0, o_COUNT=0 immediately (before next edge), no o_FLUSH_DONE.
REQ-040 SHALL test simultaneous transfer and delivery at o_COUNT=3 -> o_COUNT stays 3 across 10 cycles.

Source files
------------

// File: rtl/fft_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fft_ctrl_pkg
//  Purpose  : Shared state encoding and helpers for the pipeline flow
//             controller family.
//  Revision : 1.0 - initial release
// ============================================================================
package fft_ctrl_pkg;

    localparam int STATE_W = 2;

    // Controller states; the encoding is shared with other blocks.
    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Busy means words may still be moving through the controlled pipe.
    function automatic logic state_is_busy(input state_t s);
        return (s == RUN) || (s == FLUSH);
    endfunction

endpackage : fft_ctrl_pkg
`default_nettype wire

// File: rtl/delay_unit.sv
`default_nettype none
// ============================================================================
//  Module   : delay_unit
//  Purpose  : Generic enabled shift register of 'delay' stages, BITNESS bits
//             wide, with selectable reset style (none / sync / async, either
//             polarity).
//  Revision : 1.0 - initial release
// ============================================================================
module delay_unit #(
    parameter int BITNESS     = 8,
    parameter int delay       = 1,
    parameter int ENABLE      = 1,
    parameter int RESET       = 1,
    parameter int synch_RESET = 0,
    parameter int RESET_LEVEL = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_en,
    input  logic [BITNESS-1:0] i_din,
    output logic [BITNESS-1:0] o_dout
);

    logic [BITNESS-1:0] r_stage [0:delay-1];
    logic [BITNESS-1:0] w_d     [0:delay-1];
    logic               w_shift;

    // Without an enable the line shifts every cycle.
    generate
        if (ENABLE != 0) begin : g_enabled
            assign w_shift = i_en;
        end else begin : g_free_running
            assign w_shift = 1'b1;
        end
    endgenerate

    // Next value of every stage: stage 0 takes the input, the rest the predecessor.
    always_comb begin
        w_d[0] = i_din;
        for (int k = 1; k < delay; k++) begin
            w_d[k] = r_stage[k-1];
        end
    end

    // Stage registers; the reset flavour is chosen at elaboration time.
    generate
        if ((RESET != 0) && (synch_RESET == 0) && (RESET_LEVEL != 0)) begin : g_arst_high
            // Asynchronous active-high reset clears every stage.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < delay; k++) r_stage[k] <= '0;
                end else if (w_shift) begin
                    for (int k = 0; k < delay; k++) r_stage[k] <= w_d[k];
                end
            end
        end else if ((RESET != 0) && (synch_RESET == 0)) begin : g_arst_low
            // Asynchronous active-low reset clears every stage.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int k = 0; k < delay; k++) r_stage[k] <= '0;
                end else if (w_shift) begin
                    for (int k = 0; k < delay; k++) r_stage[k] <= w_d[k];
                end
            end
        end else if (RESET != 0) begin : g_srst
            // Synchronous reset at the configured level clears every stage.
            always_ff @(posedge clk) begin
                if (rst == (RESET_LEVEL != 0)) begin
                    for (int k = 0; k < delay; k++) r_stage[k] <= '0;
                end else if (w_shift) begin
                    for (int k = 0; k < delay; k++) r_stage[k] <= w_d[k];
                end
            end
        end else begin : g_no_reset
            // Pure data line, contents undefined until filled.
            always_ff @(posedge clk) begin
                if (w_shift) begin
                    for (int k = 0; k < delay; k++) r_stage[k] <= w_d[k];
                end
            end
        end
    endgenerate

    assign o_dout = r_stage[delay-1];

endmodule : delay_unit
`default_nettype wire

// File: rtl/pipe_flow_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_flow_ctrl
//  Purpose  : Flow controller for a fixed-latency delay line. Tracks word
//             validity through a 1-bit shadow delay line, throttles upstream,
//             stalls on downstream backpressure and sequences a drain/flush.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_flow_ctrl #(
    parameter int DELAY = 3,
    parameter int CNT_W = $clog2(DELAY + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             i_START,
    input  logic             i_FLUSH,
    input  logic             i_VALID,
    output logic             o_READY,
    output logic             o_VALID,
    input  logic             i_READY,
    output logic             o_EN,
    output logic [CNT_W-1:0] o_COUNT,
    output logic             o_BUSY,
    output logic             o_FLUSH_DONE
);

    import fft_ctrl_pkg::*;

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_count_next;
    logic               w_en;
    logic               w_out_vld;
    logic               w_transfer;
    logic               w_delivery;

    // The whole line only stalls when the word at the output is not taken.
    assign w_en = ~w_out_vld | i_READY;

    // Upstream is accepted only while running; a flush request closes the
    // input in the same cycle it arrives.
    assign o_READY    = w_en & (r_state == RUN) & ~i_FLUSH;
    assign w_transfer = i_VALID & o_READY;
    assign w_delivery = w_out_vld & i_READY;

    // Shadow valid chain: one bit per stage of the controlled data line.
    delay_unit #(
        .BITNESS     (1),
        .delay       (DELAY),
        .ENABLE      (1),
        .RESET       (1),
        .synch_RESET (0),
        .RESET_LEVEL (1)
    ) u_vld_chain (
        .clk    (CLK),
        .rst    (RST),
        .i_en   (w_en),
        .i_din  (w_transfer),
        .o_dout (w_out_vld)
    );

    // Occupancy: words enter on transfer and leave on delivery.
    always_comb begin
        w_count_next = r_count;
        case ({w_transfer, w_delivery})
            2'b10:   w_count_next = r_count + CNT_W'(1);
            2'b01:   w_count_next = r_count - CNT_W'(1);
            default: w_count_next = r_count;
        endcase
    end

    // Occupancy register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_next;
        end
    end

    // Next-state logic; flush has priority over start in IDLE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (i_FLUSH) begin
                    w_state_next = DONE;
                end else if (i_START) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (i_FLUSH) begin
                    w_state_next = FLUSH;
                end
            end
            FLUSH: begin
                // Leave as soon as the last word is delivered, not a cycle later.
                if (w_count_next == '0) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    assign o_EN         = w_en;
    assign o_VALID      = w_out_vld;
    assign o_COUNT      = r_count;
    assign o_BUSY       = state_is_busy(r_state);
    assign o_FLUSH_DONE = (r_state == DONE);

endmodule : pipe_flow_ctrl
`default_nettype wire

// File: tb/tb_pipe_flow_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_flow_ctrl
//  Purpose  : Directed self-checking bench for pipe_flow_ctrl (DELAY=3) with
//             a transfer/delivery scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_flow_ctrl;

    localparam int DELAY = 3;
    localparam int CNT_W = $clog2(DELAY + 1);

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             i_START = 1'b0;
    logic             i_FLUSH = 1'b0;
    logic             i_VALID = 1'b0;
    logic             i_READY = 1'b0;
    logic             o_READY;
    logic             o_VALID;
    logic             o_EN;
    logic [CNT_W-1:0] o_COUNT;
    logic             o_BUSY;
    logic             o_FLUSH_DONE;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int deliveries = 0;
    int max_cnt = 0;
    bit strict_lat = 1'b0;
    int q[$];

    pipe_flow_ctrl #(.DELAY(DELAY)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .i_START      (i_START),
        .i_FLUSH      (i_FLUSH),
        .i_VALID      (i_VALID),
        .o_READY      (o_READY),
        .o_VALID      (o_VALID),
        .i_READY      (i_READY),
        .o_EN         (o_EN),
        .o_COUNT      (o_COUNT),
        .o_BUSY       (o_BUSY),
        .o_FLUSH_DONE (o_FLUSH_DONE)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Apply inputs just after a rising edge, then move to the sampling point.
    task automatic drive(input logic s, input logic f, input logic v, input logic r);
        i_START = s;
        i_FLUSH = f;
        i_VALID = v;
        i_READY = r;
        @(negedge CLK);
    endtask

    // Scoreboard bookkeeping at the sampling point, then step one cycle.
    task automatic adv();
        int t;
        check("count_vs_sb", {{(32-CNT_W){1'b0}}, o_COUNT}, q.size());
        if (int'(o_COUNT) > max_cnt) max_cnt = int'(o_COUNT);
        if (o_VALID && i_READY) begin
            deliveries++;
            check("sb_nonempty", (q.size() != 0), 1);
            if (q.size() != 0) begin
                t = q.pop_front();
                if (strict_lat) check("latency_exact", cyc - t, DELAY);
                else            check("latency_min", (cyc - t) >= DELAY, 1);
            end
        end
        if (i_VALID && o_READY) q.push_back(cyc);
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    // From RUN with an empty pipe: flush, watch the single done pulse, back to IDLE.
    task automatic return_idle(input string tag);
        drive(0, 1, 0, 1);
        check({tag, "_flush_ready"}, o_READY, 0);
        adv();
        drive(0, 0, 0, 1);
        check({tag, "_flush_busy"}, o_BUSY, 1);
        adv();
        drive(0, 0, 0, 1);
        check({tag, "_done_pulse"}, o_FLUSH_DONE, 1);
        adv();
        drive(0, 0, 0, 1);
        check({tag, "_done_clear"}, o_FLUSH_DONE, 0);
        check({tag, "_idle_busy"}, o_BUSY, 0);
        adv();
    endtask

    initial begin
        // Reset state
        @(negedge CLK);
        check("rst_count", {{(32-CNT_W){1'b0}}, o_COUNT}, 0);
        check("rst_valid", o_VALID, 0);
        check("rst_ready", o_READY, 0);
        check("rst_done", o_FLUSH_DONE, 0);
        check("rst_busy", o_BUSY, 0);
        check("rst_en", o_EN, 1);
        @(posedge CLK);
        #1;
        RST = 1'b0;

        // Stream: five back-to-back words, no backpressure
        strict_lat = 1'b1;
        max_cnt = 0;
        drive(1, 0, 0, 1);
        check("stream_idle_ready", o_READY, 0);
        adv();
        for (int k = 1; k <= 12; k++) begin
            drive(0, 0, (k <= 5), 1);
            if (k == 1) begin
                check("stream_run_ready", o_READY, 1);
                check("stream_run_busy", o_BUSY, 1);
            end
            check($sformatf("stream_ovalid_c%0d", k), o_VALID, (k >= 4 && k <= 8));
            adv();
        end
        check("stream_max_count", max_cnt, 3);
        check("stream_final_count", {{(32-CNT_W){1'b0}}, o_COUNT}, 0);
        return_idle("stream");

        // Backpressure: fill three words, stall, then drain
        strict_lat = 1'b0;
        drive(1, 0, 0, 0);
        adv();
        for (int k = 1; k <= 3; k++) begin
            drive(0, 0, 1, 0);
            check("bp_fill_en", o_EN, 1);
            adv();
        end
        for (int k = 4; k <= 6; k++) begin
            drive(0, 0, 1, 0);
            check("bp_stall_en", o_EN, 0);
            check("bp_stall_ready", o_READY, 0);
            check("bp_stall_count", {{(32-CNT_W){1'b0}}, o_COUNT}, 3);
            check("bp_stall_valid", o_VALID, 1);
            adv();
        end
        deliveries = 0;
        for (int k = 7; k <= 10; k++) begin
            drive(0, 0, 0, 1);
            check($sformatf("bp_drain_valid_c%0d", k), o_VALID, (k <= 9));
            adv();
        end
        check("bp_deliveries", deliveries, 3);
        check("bp_sb_empty", q.size(), 0);
        return_idle("bp");

        // Flush with two words in flight
        strict_lat = 1'b1;
        drive(1, 0, 0, 1);
        adv();
        for (int k = 1; k <= 2; k++) begin
            drive(0, 0, 1, 1);
            adv();
        end
        drive(0, 1, 1, 1);
        check("fl_ready_same_cycle", o_READY, 0);
        check("fl_count2", {{(32-CNT_W){1'b0}}, o_COUNT}, 2);
        adv();
        drive(0, 0, 1, 1);
        check("fl_busy", o_BUSY, 1);
        check("fl_valid", o_VALID, 1);
        check("fl_ready_closed", o_READY, 0);
        check("fl_no_early_done", o_FLUSH_DONE, 0);
        adv();
        drive(0, 0, 1, 1);
        check("fl_count1", {{(32-CNT_W){1'b0}}, o_COUNT}, 1);
        check("fl_no_early_done2", o_FLUSH_DONE, 0);
        adv();
        drive(0, 0, 1, 1);
        check("fl_done_pulse", o_FLUSH_DONE, 1);
        check("fl_done_count", {{(32-CNT_W){1'b0}}, o_COUNT}, 0);
        check("fl_done_busy", o_BUSY, 0);
        adv();
        drive(0, 0, 1, 1);
        check("fl_done_clear", o_FLUSH_DONE, 0);
        check("fl_idle_ready", o_READY, 0);
        adv();

        // Idle flush with simultaneous start: flush wins
        drive(1, 1, 0, 1);
        check("if_busy0", o_BUSY, 0);
        adv();
        drive(0, 0, 0, 1);
        check("if_done_pulse", o_FLUSH_DONE, 1);
        check("if_busy1", o_BUSY, 0);
        adv();
        drive(0, 0, 0, 1);
        check("if_done_clear", o_FLUSH_DONE, 0);
        check("if_busy2", o_BUSY, 0);
        check("if_not_run", o_READY, 0);
        adv();

        // Simultaneous transfer and delivery at full occupancy
        strict_lat = 1'b1;
        drive(1, 0, 0, 1);
        adv();
        for (int k = 1; k <= 3; k++) begin
            drive(0, 0, 1, 1);
            adv();
        end
        for (int k = 4; k <= 13; k++) begin
            drive(0, 0, 1, 1);
            check("full_count_hold", {{(32-CNT_W){1'b0}}, o_COUNT}, 3);
            check("full_ready", o_READY, 1);
            adv();
        end
        for (int k = 14; k <= 16; k++) begin
            drive(0, 0, 0, 1);
            adv();
        end

        // Mid-stream reset with two words in flight
        strict_lat = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            drive(0, 0, 1, 0);
            adv();
        end
        drive(0, 0, 0, 0);
        check("mr_count2_a", {{(32-CNT_W){1'b0}}, o_COUNT}, 2);
        adv();
        drive(0, 0, 0, 0);
        check("mr_valid_before", o_VALID, 1);
        check("mr_count2_b", {{(32-CNT_W){1'b0}}, o_COUNT}, 2);
        #2;
        RST = 1'b1;
        #1;
        check("mr_valid_async", o_VALID, 0);
        check("mr_count_async", {{(32-CNT_W){1'b0}}, o_COUNT}, 0);
        check("mr_busy_async", o_BUSY, 0);
        check("mr_done_async", o_FLUSH_DONE, 0);
        check("mr_en_async", o_EN, 1);
        q.delete();
        @(posedge CLK);
        #1;
        RST = 1'b0;
        cyc++;
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 0, 1);
            check("mr_no_done", o_FLUSH_DONE, 0);
            check("mr_idle_busy", o_BUSY, 0);
            adv();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_pipe_flow_ctrl
`default_nettype wire
